// File: rtl/pop_arb_pkg.sv
// Shared types and constants for the two-lane pop arbiter.
// Imported by rr_pick2 and pop_arbiter2.
package pop_arb_pkg;

    typedef enum logic {
        RR_L0 = 1'b0,
        RR_L1 = 1'b1
    } rr_state_t;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/pop_arbiter2_pick.sv
// Combinational round-robin pick between two FIFO lanes.
// An empty lane is never chosen; a lone non-empty lane always wins.
module rr_pick2
    import pop_arb_pkg::*;
(
    input  logic      empty0,
    input  logic      empty1,
    input  logic      go,
    input  rr_state_t rr,
    output logic      read0,
    output logic      read1,
    output logic      lane
);

    logic fav0;
    logic fav1;

    // Lane choice: favoured lane wins a tie, otherwise the lone ready lane.
    always_comb begin
        fav0  = (rr == RR_L0);
        fav1  = (rr == RR_L1);
        read0 = go & ~empty0 & (empty1 | fav0);
        read1 = go & ~empty1 & (empty0 | fav1);
        lane  = read1 ? LANE1 : LANE0;
    end

endmodule

// File: rtl/pop_arbiter2.sv
// Round-robin drain of two FIFO lanes into one registered push stream.
// Pops are combinational; data lands two cycles after the pop.
module pop_arbiter2
    import pop_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          empty0,
    input  logic          empty1,
    input  logic [DW-1:0] out0,
    input  logic [DW-1:0] out1,
    input  logic          af_dest,
    output logic          read0,
    output logic          read1,
    output logic [DW-1:0] data_out,
    output logic          push,
    output logic          lane_out,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic          idle
);

    rr_state_t     rr_q, rr_d;
    logic          v1_q, v1_d;
    logic          l1_q, l1_d;
    logic [DW-1:0] data_q, data_d;
    logic          push_q, push_d;
    logic          lane_q, lane_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic go;
    logic pick_lane;

    // Reset gates go so no pop can leak out while reset is held.
    assign go = enable & ~af_dest & reset;

    rr_pick2 u_pick (
        .empty0 (empty0),
        .empty1 (empty1),
        .go     (go),
        .rr     (rr_q),
        .read0  (read0),
        .read1  (read1),
        .lane   (pick_lane)
    );

    // Round-robin pointer: move to the other lane after every pop.
    always_comb begin
        rr_d = rr_q;
        unique case (1'b1)
            read0:   rr_d = RR_L1;
            read1:   rr_d = RR_L0;
            default: rr_d = rr_q;
        endcase
    end

    // Stage 1/2 next state and pop counters.
    always_comb begin
        v1_d   = read0 | read1;
        l1_d   = pick_lane;
        push_d = v1_q;
        data_d = data_q;
        lane_d = lane_q;
        if (v1_q) begin
            data_d = l1_q ? out1 : out0;
            lane_d = l1_q;
        end
        cnt0_d = cnt0_q + {{(CW-1){1'b0}}, read0};
        cnt1_d = cnt1_q + {{(CW-1){1'b0}}, read1};
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q   <= RR_L0;
            v1_q   <= 1'b0;
            l1_q   <= LANE0;
            data_q <= '0;
            push_q <= 1'b0;
            lane_q <= LANE0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            rr_q   <= rr_d;
            v1_q   <= v1_d;
            l1_q   <= l1_d;
            data_q <= data_d;
            push_q <= push_d;
            lane_q <= lane_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign data_out = data_q;
    assign push     = push_q;
    assign lane_out = lane_q;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;
    assign idle     = ~read0 & ~read1 & ~v1_q & ~push_q;

endmodule

// File: doc/pop_arbiter2.md
# pop_arbiter2

Round-robin drain stage that sits directly downstream of `device2`. It consumes the two 8-bit FIFO outputs (`out0`/`out1`, qualified by `empty0`/`empty1`), issues `read0`/`read1` pops, and merges both streams into one registered 8-bit push stream toward a single destination FIFO. It honours that FIFO's almost-full backpressure and keeps 8-bit per-lane pop counters for debug.

## Interface
Parameters:
- `DW`, 8: data width, matching the `device2` FIFO width.
- `CW`, 8: width of each pop counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `enable`  in  1  1 = new pops allowed; 0 = no new pops, in-flight data still completes.
- `empty0`  in  1  lane-0 FIFO empty.
- `empty1`  in  1  lane-1 FIFO empty.
- `out0`  in  DW  lane-0 FIFO read data; valid the cycle after `read0`.
- `out1`  in  DW  lane-1 FIFO read data; valid the cycle after `read1`.
- `af_dest`  in  1  destination FIFO almost-full.
- `read0`  out  1  lane-0 pop; combinational from state and current inputs.
- `read1`  out  1  lane-1 pop; combinational from state and current inputs.
- `data_out`  out  DW  merged data, registered.
- `push`  out  1  `data_out` valid, write strobe to the destination.
- `lane_out`  out  1  source lane of the current `data_out`.
- `cnt0`  out  CW  lane-0 pops since reset; wraps.
- `cnt1`  out  CW  lane-1 pops since reset; wraps.
- `idle`  out  1  no pop issued this cycle and none in flight.

## Operation
Pop decision, evaluated each cycle:
- `go = enable & ~af_dest`.
- No pop when `go` = 0 or both lanes are empty.
- Exactly one lane non-empty: pop that lane.
- Both lanes non-empty: pop the lane selected by the round-robin pointer `rr`.
  - `rr` = 0 favours lane 0.
  - After any pop, `rr` is set to the other lane.
- `read0` and `read1` are never high together.

State `rr_st`, values taken from the package:
- `RR_L0` (reset value): lane 0 favoured.
- `RR_L1`: lane 1 favoured.
- Transitions: pop from lane 0 → `RR_L1`; pop from lane 1 → `RR_L0`; no pop → hold.

Pipeline:
- Stage 1 flops `v1` and `l1` record the pop and its lane.
- Stage 2: when `v1` = 1, capture `l1 ? out1 : out0` into `data_out`, with `push` = 1 and `lane_out` = `l1`.
- Otherwise `push` = 0 and `data_out` holds its last value.

Counters:
- `cnt0`/`cnt1` increment in the cycle after the corresponding pop, together with stage 1.
- Counters wrap modulo 2^CW: 255 → 0.

`idle = ~read0 & ~read1 & ~v1 & ~push`.

Boundaries:
- An empty lane is never popped, regardless of `rr`.
- Deassertion of `enable` or assertion of `af_dest` blocks new pops only; up to 2 items already in flight still push.
- The destination almost-full threshold must leave at least 2 free slots.
- Reset mid-operation clears in-flight data, which is dropped, not replayed.

Reset values: `read0`/`read1` = 0, `push` = 0, `data_out` = 0, `lane_out` = 0, `cnt0`/`cnt1` = 0, `rr_st` = `RR_L0`, `v1` = 0, `idle` = 1.

## Timing
- Pop in cycle N → `push` high in cycle N+2, carrying the FIFO word presented in cycle N+1.
- Sustained throughput is 1 push per cycle while data and credit are available.
- Both lanes continuously non-empty → pops alternate 0,1,0,1… starting with lane 0 after reset.
- `af_dest` sampled high in cycle N → no pop in cycle N; at most 2 further pushes (cycles N, N+1).
- `read0`/`read1` are combinational from the current-cycle `empty*`, `af_dest` and `enable`; there is no registered read.

## Structure
Package `pop_arb_pkg` holds:
- state enum `rr_state_t` (`RR_L0`, `RR_L1`);
- `DW_DEF` = 8 and `CW_DEF` = 8;
- lane constants `LANE0` = 0 and `LANE1` = 1.

Sub-module `rr_pick2`: purely combinational, taking `empty0`, `empty1`, `go`, `rr` and producing `read0`, `read1`, `lane`. It is instantiated once; the top level holds the flops, pipeline and counters.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with both lanes non-empty → `read*`, `push` and counters all 0, `idle` = 1.
- Alternation: release reset; both lanes non-empty; lane 0 supplies 0xA0…, lane 1 supplies 0xB0… → push sequence A0,B0,A1,B1, with first `push` 2 cycles after the first `read0`.
- Single lane: `empty0` = 1; lane 1 supplies 5 words → 5 consecutive `read1`, no `read0`, `cnt1` = 5, `lane_out` = 1 throughout.
- Backpressure: raise `af_dest` mid-stream → pops stop the same cycle, at most 2 trailing pushes; lower it → pops resume on the lane that was next in the round-robin order.
- Counter wrap: 256 lane-0 pops → `cnt0` returns to 0.
- Reset mid-flight: assert `reset` in the cycle after a pop → `push` stays 0 and that word is never delivered.
